// File: rtl/blk_timing.sv
// Block-grid timing generator: delays the pixel stream by one cycle and marks
// the last pixel of each horizontal block (h_save_o) and of each block row (v_save_o).
module blk_timing #(
  parameter int HBLKS   = 10,
  parameter int VBLKS   = 10,
  parameter int HBLK_PX = 30,
  parameter int VBLK_LN = 30
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic [23:0] wd_i,
  output logic        de_o,
  output logic [23:0] wd_o,
  output logic        h_save_o,
  output logic        v_save_o,
  output logic        err_o
);

  // state     | meaning
  // WAIT_VS   | idle after reset, waiting for a frame start
  // ACTIVE    | counting pixels/blocks/lines of the current frame
  // DONE      | whole block grid seen; further pixels are errors
  localparam logic [1:0] ST_WAIT_VS = 2'd0;
  localparam logic [1:0] ST_ACTIVE  = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam int PX_W = (HBLK_PX > 1) ? $clog2(HBLK_PX) : 1;
  localparam int BX_W = $clog2(HBLKS + 1);
  localparam int LN_W = (VBLK_LN > 1) ? $clog2(VBLK_LN) : 1;
  localparam int BY_W = (VBLKS > 1) ? $clog2(VBLKS) : 1;

  localparam logic [PX_W-1:0] PX_LAST = PX_W'(HBLK_PX - 1);
  localparam logic [PX_W-1:0] PX_ONE  = PX_W'(1);
  localparam logic [BX_W-1:0] BX_END  = BX_W'(HBLKS);
  localparam logic [BX_W-1:0] BX_LAST = BX_W'(HBLKS - 1);
  localparam logic [BX_W-1:0] BX_ONE  = BX_W'(1);
  localparam logic [LN_W-1:0] LN_LAST = LN_W'(VBLK_LN - 1);
  localparam logic [LN_W-1:0] LN_ONE  = LN_W'(1);
  localparam logic [BY_W-1:0] BY_LAST = BY_W'(VBLKS - 1);
  localparam logic [BY_W-1:0] BY_ONE  = BY_W'(1);

  logic [1:0]      state_q, state_d;
  logic [PX_W-1:0] px_cnt, px_d;
  logic [BX_W-1:0] bx_cnt, bx_d;
  logic [LN_W-1:0] ln_cnt, ln_d;
  logic [BY_W-1:0] by_cnt, by_d;
  logic            err_d, h_d, v_d;
  logic            vs_q, armed_q, vs_rise, active;

  // armed_q blocks a vs_i held high through reset release from looking like an edge
  assign vs_rise = vs_i & ~vs_q & armed_q;
  assign active  = vs_rise | (state_q == ST_ACTIVE);

  always_comb begin
    state_d = state_q;
    px_d    = px_cnt;
    bx_d    = bx_cnt;
    ln_d    = ln_cnt;
    by_d    = by_cnt;
    err_d   = err_o;
    h_d     = 1'b0;
    v_d     = 1'b0;

    if (vs_rise) begin
      state_d = ST_ACTIVE;
      px_d    = '0;
      bx_d    = '0;
      ln_d    = '0;
      by_d    = '0;
      err_d   = de_i;
    end

    if (active && de_i) begin
      if (bx_d == BX_END) begin
        err_d = 1'b1;
      end else if (px_d == PX_LAST) begin
        h_d  = 1'b1;
        v_d  = (bx_d == BX_LAST) && (ln_d == LN_LAST);
        px_d = '0;
        bx_d = bx_d + BX_ONE;
      end else begin
        px_d = px_d + PX_ONE;
      end
    end else if (active && !vs_rise && !de_i && de_o) begin
      if ((px_d != '0) || (bx_d != BX_END)) err_d = 1'b1;
      px_d = '0;
      bx_d = '0;
      if (ln_d == LN_LAST) begin
        ln_d = '0;
        if (by_d == BY_LAST) begin
          by_d    = '0;
          state_d = ST_DONE;
        end else begin
          by_d = by_d + BY_ONE;
        end
      end else begin
        ln_d = ln_d + LN_ONE;
      end
    end

    if (!vs_rise && (state_q == ST_DONE) && de_i) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_WAIT_VS;
      px_cnt   <= '0;
      bx_cnt   <= '0;
      ln_cnt   <= '0;
      by_cnt   <= '0;
      vs_q     <= 1'b0;
      armed_q  <= 1'b0;
      de_o     <= 1'b0;
      wd_o     <= '0;
      h_save_o <= 1'b0;
      v_save_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state_q  <= state_d;
      px_cnt   <= px_d;
      bx_cnt   <= bx_d;
      ln_cnt   <= ln_d;
      by_cnt   <= by_d;
      vs_q     <= vs_i;
      if (!vs_i) armed_q <= 1'b1;
      de_o     <= de_i;
      wd_o     <= wd_i;
      h_save_o <= h_d;
      v_save_o <= v_d;
      err_o    <= err_d;
    end
  end

endmodule

// File: tb/tb_blk_timing.sv
// Directed bench for blk_timing with a 4x3 block grid of 2x2-pixel blocks
// (8 pixels per line, 6 lines per frame).
module tb_blk_timing;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        vs_i;
  logic        de_i;
  logic [23:0] wd_i;
  logic        de_o;
  logic [23:0] wd_o;
  logic        h_save_o;
  logic        v_save_o;
  logic        err_o;

  int vectors = 0;
  int miscompares = 0;

  blk_timing #(.HBLKS(4), .VBLKS(3), .HBLK_PX(2), .VBLK_LN(2)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .vs_i     (vs_i),
    .de_i     (de_i),
    .wd_i     (wd_i),
    .de_o     (de_o),
    .wd_o     (wd_o),
    .h_save_o (h_save_o),
    .v_save_o (v_save_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  // One line of npx pixels then a 2-cycle blank. Pulses expected on odd pixels
  // below 8 when en is set; v_save_o only on pixel 7 of an odd line.
  // err_o is expected high from pixel err_from onward.
  task automatic run_line(input string tag, input int npx, input bit en,
                          input bit vodd, input int err_from, input bit vs_first);
    logic exp_h, exp_v, exp_e;
    logic [23:0] wd_exp;
    for (int i = 0; i < npx; i++) begin
      @(negedge clk_i);
      vs_i = vs_first && (i == 0);
      de_i = 1'b1;
      wd_i = 24'($urandom);
      wd_exp = wd_i;
      @(posedge clk_i);
      #1;
      exp_h = en && (i % 2 == 1) && (i < 8);
      exp_v = exp_h && (i == 7) && vodd;
      exp_e = (i >= err_from);
      vectors += 5;
      if (de_o !== 1'b1) begin
        miscompares++;
        $display("FAIL %s px%0d de_o: got %b want 1", tag, i, de_o);
      end
      if (wd_o !== wd_exp) begin
        miscompares++;
        $display("FAIL %s px%0d wd_o: got %h want %h", tag, i, wd_o, wd_exp);
      end
      if (h_save_o !== exp_h) begin
        miscompares++;
        $display("FAIL %s px%0d h_save_o: got %b want %b", tag, i, h_save_o, exp_h);
      end
      if (v_save_o !== exp_v) begin
        miscompares++;
        $display("FAIL %s px%0d v_save_o: got %b want %b", tag, i, v_save_o, exp_v);
      end
      if (err_o !== exp_e) begin
        miscompares++;
        $display("FAIL %s px%0d err_o: got %b want %b", tag, i, err_o, exp_e);
      end
    end
    for (int g = 0; g < 2; g++) begin
      @(negedge clk_i);
      vs_i = 1'b0;
      de_i = 1'b0;
      wd_i = 24'($urandom);
      wd_exp = wd_i;
      @(posedge clk_i);
      #1;
      vectors += 3;
      if (wd_o !== wd_exp) begin
        miscompares++;
        $display("FAIL %s gap%0d wd_o: got %h want %h", tag, g, wd_o, wd_exp);
      end
      if (de_o !== 1'b0 || h_save_o !== 1'b0) begin
        miscompares++;
        $display("FAIL %s gap%0d de_o/h_save_o: got %b/%b want 0/0", tag, g, de_o, h_save_o);
      end
      if (v_save_o !== 1'b0) begin
        miscompares++;
        $display("FAIL %s gap%0d v_save_o: got %b want 0", tag, g, v_save_o);
      end
    end
  endtask

  task automatic vs_pulse(input string tag);
    @(negedge clk_i);
    vs_i = 1'b1;
    de_i = 1'b0;
    @(posedge clk_i);
    #1;
    vectors++;
    if (err_o !== 1'b0 || h_save_o !== 1'b0 || v_save_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s vs err/h/v: got %b%b%b want 000", tag, err_o, h_save_o, v_save_o);
    end
    @(negedge clk_i);
    vs_i = 1'b0;
    @(posedge clk_i);
  endtask

  task automatic test_reset();
    logic [23:0] wd_exp;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      rst_ni = 1'b0;
      de_i = 1'b1;
      wd_i = 24'($urandom);
      @(posedge clk_i);
      #1;
      vectors++;
      if ({de_o, wd_o, h_save_o, v_save_o, err_o} !== 28'd0) begin
        miscompares++;
        $display("FAIL reset outputs: got de=%b wd=%h h=%b v=%b e=%b want all 0",
                 de_o, wd_o, h_save_o, v_save_o, err_o);
      end
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    de_i = 1'b0;
    wd_i = 24'hA5A5A5;
    wd_exp = wd_i;
    @(posedge clk_i);
    #1;
    vectors++;
    if (wd_o !== wd_exp) begin
      miscompares++;
      $display("FAIL reset_release wd_o: got %h want %h", wd_o, wd_exp);
    end
  endtask

  task automatic test_wait_vs();
    run_line("wait_vs", 8, 1'b0, 1'b0, 1000, 1'b0);
  endtask

  task automatic test_full_frame();
    vs_pulse("frame");
    for (int l = 0; l < 6; l++) run_line($sformatf("frame_ln%0d", l), 8, 1'b1, l[0], 1000, 1'b0);
  endtask

  task automatic test_done();
    run_line("done_ln6", 8, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_vs_with_de();
    run_line("vs_de_ln0", 8, 1'b1, 1'b0, 0, 1'b1);
    run_line("vs_de_ln1", 8, 1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_overflow();
    vs_pulse("ovf");
    run_line("ovf_ln0", 10, 1'b1, 1'b0, 8, 1'b0);
    vectors++;
    if (err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf sticky err_o: got %b want 1", err_o);
    end
    vs_pulse("ovf_clear");
  endtask

  task automatic test_short_line();
    run_line("short_ln0", 5, 1'b1, 1'b0, 1000, 1'b0);
    vectors++;
    if (err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL short line-end err_o: got %b want 1", err_o);
    end
    run_line("short_ln1", 8, 1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_mid_reset();
    vs_pulse("mrst");
    run_line("mrst_ln0", 8, 1'b1, 1'b0, 1000, 1'b0);
    run_line("mrst_ln1", 8, 1'b1, 1'b1, 1000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      de_i = 1'b1;
      wd_i = 24'($urandom);
    end
    @(negedge clk_i);
    rst_ni = 1'b0;
    wd_i = 24'($urandom);
    @(posedge clk_i);
    #1;
    vectors++;
    if ({de_o, wd_o, h_save_o, v_save_o, err_o} !== 28'd0) begin
      miscompares++;
      $display("FAIL mid_reset outputs: got de=%b wd=%h h=%b v=%b e=%b want all 0",
               de_o, wd_o, h_save_o, v_save_o, err_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_line("mrst_rest", 5, 1'b0, 1'b0, 1000, 1'b0);
    for (int l = 3; l < 6; l++) run_line($sformatf("mrst_ln%0d", l), 8, 1'b0, 1'b0, 1000, 1'b0);
    vs_pulse("mrst_restart");
    run_line("mrst_new0", 8, 1'b1, 1'b0, 1000, 1'b0);
    run_line("mrst_new1", 8, 1'b1, 1'b1, 1000, 1'b0);
  endtask

  task automatic test_vs_held_through_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    vs_i = 1'b1;
    de_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    run_line("vs_held", 8, 1'b0, 1'b0, 1000, 1'b0);
    vs_pulse("vs_held_restart");
    run_line("vs_held_new0", 8, 1'b1, 1'b0, 1000, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0;
    vs_i = 1'b0;
    de_i = 1'b0;
    wd_i = '0;
    test_reset();
    test_wait_vs();
    test_full_frame();
    test_done();
    test_vs_with_de();
    test_overflow();
    test_short_line();
    test_mid_reset();
    test_vs_held_through_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
